mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, is the maximum number of cycles a memory state waits for mem_ready before faulting (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 memwrite, irwrite, iord, alusrca, regwrite, pcen  output  1 each  datapath strobes and selects.
REQ-010 regdst, memtoreg, alusrcb, pcsrc  output  2 each  datapath mux selects.
REQ-011 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 fault  output  1  sticky error flag.

Function
REQ-013 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR.
REQ-014 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; irwrite=1 and pcen=1 only in the cycle mem_ready=1; advance to DECODE on mem_ready, else hold.
REQ-015 DECODE: alusrcb=11, alucontrol=010; next state by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> ERROR.
REQ-016 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; -> MEMRD if op=100011, else MEMWR.
REQ-017 MEMRD: mem_req=1, iord=1; -> MEMWB on mem_ready. MEMWB: regwrite=1, regdst=00, memtoreg=01; -> FETCH.
REQ-018 MEMWR: mem_req=1, iord=1, memwrite=1; -> FETCH on mem_ready.
REQ-019 EXEC: alusrca=1, alusrcb=00, alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); -> ALUWB; unknown funct -> ERROR.
REQ-020 ALUWB: regwrite=1, regdst=01, memtoreg=00; -> FETCH.
REQ-021 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero (combinational); -> FETCH.
REQ-022 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010; -> ADDIWB. ADDIWB: regwrite=1, regdst=00, memtoreg=00; -> FETCH.
REQ-023 JUMP: pcsrc=10, pcen=1; -> FETCH.
REQ-024 Wait counter (8 bit) clears on entering any memory state, increments each cycle mem_ready=0 in FETCH/MEMRD/MEMWR; reaching WAIT_LIMIT with mem_ready=0 -> ERROR; mem_ready=1 on the limit cycle completes normally.
REQ-025 ERROR: fault=1, all strobes 0; state held until reset.
REQ-026 Outputs not listed for a state are 0 (selects 00); each instruction occupies exactly its listed states, minimum latency: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles with mem_ready held high.

Reset
REQ-027 reset asserted forces state FETCH, wait counter 0, fault 0 immediately, regardless of clk.
REQ-028 While reset is high all outputs are 0 except FETCH selects; mem_req=0, pcen=0, irwrite=0.
REQ-029 Reset mid-access (e.g. in MEMWR) drops memwrite and mem_req in the same cycle; first post-reset rising edge enters FETCH with mem_req=1.

Configuration
REQ-030 Macro MC_CONTROLLER_JAL_EN defined: op 000011 -> JAL state: pcsrc=10, pcen=1, regwrite=1, regdst=10, memtoreg=10 (link = PC+4); -> FETCH.
REQ-031 Macro undefined: op 000011 decodes as illegal -> ERROR; regdst/memtoreg never drive 10.

Verification
REQ-032 lw, mem_ready always 1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=01 in cycle 5 only.
REQ-033 beq with zero=1 then zero=0 -> pcen=1, pcsrc=01 in BRANCH for first; pcen=0 for second; both return to FETCH.
REQ-034 FETCH with mem_ready=0 for 3 cycles then 1 -> irwrite/pcen pulse once in cycle 4; no fault.
REQ-035 WAIT_LIMIT=4, mem_ready stuck 0 in MEMWR -> ERROR after 4 cycles, fault=1, memwrite=0, held until reset.
REQ-036 R-type funct 100010 -> alucontrol=110 in EXEC; funct 000111 -> ERROR.
REQ-037 Reset asserted mid-MEMRD between clock edges -> outputs drop asynchronously; op 000011 -> JAL writeback with macro, ERROR without.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM with memory handshake and wait-limit fault.
// Defining MC_CONTROLLER_JAL_EN adds a JAL state (op 000011); otherwise that opcode is illegal.
module mc_controller #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       fault
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CONTROLLER_JAL_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Last waiting cycle index; a not-ready cycle at this count faults.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_ERROR
`ifdef MC_CONTROLLER_JAL_EN
        , S_JAL
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_state;
    logic       timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = !mem_ready && (wait_q >= WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regwrite   = 1'b0;
        pcen       = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROLLER_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: state_d = S_ERROR;
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_CONTROLLER_JAL_EN
            S_JAL: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
                state_d  = S_FETCH;
            end
`endif
            S_ERROR: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        // Any state change restarts the wait budget for the next memory state.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_state && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end

        // Reset parks in FETCH but must not issue a request or strobe the PC/IR.
        if (reset) begin
            mem_req = 1'b0;
            irwrite = 1'b0;
            pcen    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed cases plus random instruction stream
// checked cycle by cycle against an instruction-level expectation builder.
module tb_mc_controller;

    localparam int WL = 4;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, irwrite, iord, alusrca, regwrite, pcen;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       fault;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       irwrite;
        logic       iord;
        logic       alusrca;
        logic       regwrite;
        logic       pcen;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       fault;
    } outs_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  zero_v;
    logic  dc_one;
    logic  plan_err;
    outs_t exp_q[$];
    logic  mr_q[$];
    string tag_q[$];
    outs_t reset_o;

    mc_controller #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .iord(iord), .alusrca(alusrca), .regwrite(regwrite),
        .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t s;
        s.mem_req    = mem_req;
        s.memwrite   = memwrite;
        s.irwrite    = irwrite;
        s.iord       = iord;
        s.alusrca    = alusrca;
        s.regwrite   = regwrite;
        s.pcen       = pcen;
        s.regdst     = regdst;
        s.memtoreg   = memtoreg;
        s.alusrcb    = alusrcb;
        s.pcsrc      = pcsrc;
        s.alucontrol = alucontrol;
        s.fault      = fault;
        return s;
    endfunction

    // {legal, alu code} for an R-type funct field
    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_000;
        endcase
    endfunction

    task automatic check(input outs_t exp, input string tag);
        outs_t obs;
        obs = sample();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step(input outs_t exp, input logic mr, input string tag);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = mr;
        zero      = zero_v;
        #1;
        check(exp, tag);
    endtask

    task automatic push(input outs_t e, input logic mr, input string tag);
        exp_q.push_back(e);
        mr_q.push_back(mr);
        tag_q.push_back(tag);
    endtask

    function automatic logic dc_bit();
        return dc_one ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    task automatic push_error();
        outs_t e;
        e       = '0;
        e.fault = 1'b1;
        plan_err = 1'b1;
        for (int i = 0; i < 3; i++) push(e, dc_bit(), "error_hold");
    endtask

    // w not-ready cycles then a ready cycle; the WL-th not-ready cycle faults instead
    task automatic push_wait(input outs_t e_wait, input outs_t e_done, input int w, input string tag);
        for (int i = 0; i < w && i < WL; i++) push(e_wait, 1'b0, {tag, "_wait"});
        if (w >= WL) push_error();
        else push(e_done, 1'b1, {tag, "_done"});
    endtask

    task automatic plan(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
        outs_t fw_e, fd_e, e;
        logic [3:0] a;
        exp_q.delete();
        mr_q.delete();
        tag_q.delete();
        plan_err = 1'b0;
        fw_e = '0;
        fw_e.mem_req = 1'b1;
        fw_e.alusrcb = 2'b01;
        fw_e.alucontrol = 3'b010;
        fd_e = fw_e;
        fd_e.irwrite = 1'b1;
        fd_e.pcen = 1'b1;
        push_wait(fw_e, fd_e, fw, "fetch");
        if (plan_err) return;
        e = '0;
        e.alusrcb = 2'b11;
        e.alucontrol = 3'b010;
        push(e, dc_bit(), "decode");
        e = '0;
        case (o)
            6'b100011, 6'b101011: begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.alucontrol = 3'b010;
                push(e, dc_bit(), "memadr");
                e = '0;
                e.mem_req = 1'b1;
                e.iord = 1'b1;
                if (o == 6'b100011) begin
                    push_wait(e, e, mw, "memrd");
                    if (!plan_err) begin
                        e = '0;
                        e.regwrite = 1'b1;
                        e.memtoreg = 2'b01;
                        push(e, dc_bit(), "memwb");
                    end
                end else begin
                    e.memwrite = 1'b1;
                    push_wait(e, e, mw, "memwr");
                end
            end
            6'b000000: begin
                a = alu_of(f);
                e.alusrca = 1'b1;
                e.alucontrol = a[2:0];
                push(e, dc_bit(), "exec");
                if (a[3]) begin
                    e = '0;
                    e.regwrite = 1'b1;
                    e.regdst = 2'b01;
                    push(e, dc_bit(), "aluwb");
                end else begin
                    push_error();
                end
            end
            6'b000100: begin
                e.alusrca = 1'b1;
                e.alucontrol = 3'b110;
                e.pcsrc = 2'b01;
                e.pcen = zero_v;
                push(e, dc_bit(), "branch");
            end
            6'b001000: begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.alucontrol = 3'b010;
                push(e, dc_bit(), "addiex");
                e = '0;
                e.regwrite = 1'b1;
                push(e, dc_bit(), "addiwb");
            end
            6'b000010: begin
                e.pcsrc = 2'b10;
                e.pcen = 1'b1;
                push(e, dc_bit(), "jump");
            end
`ifdef MC_CONTROLLER_JAL_EN
            6'b000011: begin
                e.pcsrc = 2'b10;
                e.pcen = 1'b1;
                e.regwrite = 1'b1;
                e.regdst = 2'b10;
                e.memtoreg = 2'b10;
                push(e, dc_bit(), "jal");
            end
`endif
            default: push_error();
        endcase
    endtask

    task automatic execute(input int max_steps);
        for (int i = 0; i < exp_q.size() && i < max_steps; i++) step(exp_q[i], mr_q[i], tag_q[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check(reset_o, "reset_async");
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check(reset_o, "reset_hold");
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
        op = o;
        funct = f;
        zero_v = z;
        plan(o, f, fw, mw);
        execute(exp_q.size());
        if (plan_err) do_reset();
    endtask

    initial begin
        logic [5:0] legal_f[5];
        logic [5:0] ro, rf;
        int fw, mw;
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset_o = '0;
        reset_o.alusrcb = 2'b01;
        reset_o.alucontrol = 3'b010;
        reset = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        zero_v = 1'b0;
        op = '0;
        funct = '0;
        dc_one = 1'b1;
        #1;
        check(reset_o, "reset_init");
        @(negedge clk);
        #1;
        check(reset_o, "reset_init_hold");

        run(6'b100011, 6'b0, 1'b0, 0, 0);
        run(6'b000100, 6'b0, 1'b1, 0, 0);
        run(6'b000100, 6'b0, 1'b0, 0, 0);
        run(6'b000010, 6'b0, 1'b0, 3, 0);
        run(6'b101011, 6'b0, 1'b0, 0, WL);
        run(6'b101011, 6'b0, 1'b0, 0, WL - 1);
        run(6'b000000, 6'b100010, 1'b0, 0, 0);
        run(6'b000000, 6'b000111, 1'b0, 0, 0);
        run(6'b000000, 6'b0, 1'b0, WL, 0);

        op = 6'b100011;
        funct = '0;
        plan(op, funct, 0, 2);
        execute(4);
        #2;
        do_reset();

        run(6'b000011, 6'b0, 1'b0, 0, 0);
        run(6'b001000, 6'b0, 1'b1, 1, 0);

        dc_one = 1'b0;
        for (int n = 0; n < 40; n++) begin
            fw = ($urandom_range(0, 9) == 0) ? WL : int'($urandom_range(0, WL - 1));
            mw = ($urandom_range(0, 9) == 0) ? WL : int'($urandom_range(0, WL - 1));
            rf = legal_f[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2, 3: ro = 6'b000000;
                4: ro = 6'b000100;
                5: ro = 6'b001000;
                6: ro = 6'b000010;
                7: ro = 6'b000011;
                8: begin ro = 6'b000000; rf = 6'($urandom); end
                default: ro = 6'($urandom);
            endcase
            run(ro, rf, 1'($urandom_range(0, 1)), fw, mw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
